// File: rtl/xgmii_crossbar_n.sv
// xgmii_crossbar_n
//   NUM_PORTS x NUM_PORTS XGMII frame switch. Every ingress word carries a
//   destination egress index (route_map), but the index is only read on SOF.
//   Each egress runs its own IDLE / FWD(src) FSM. In IDLE it grants one SOF by
//   round-robin. In FWD it forwards the granted ingress until that ingress
//   shows EOF. All outputs are registered, so forward latency is 1 cycle.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous, active-low reset
//   eth_in_xgmii_ctrl   8  bits per ingress port, port i at [8i+7:8i]
//   eth_in_xgmii_data   64 bits per ingress port, port i at [64i+63:64i]
//   route_map           IDX_W bits per ingress port: destination egress
//   eth_out_xgmii_ctrl  8  bits per egress, registered
//   eth_out_xgmii_data  64 bits per egress, registered
//   drop_cnt            CNT_W bits per egress: SOFs lost to contention (saturating)
//   err_cnt             CNT_W bits per egress: frames aborted by a new SOF (saturating)
//   fwd_state           1 bit per egress: egress FSM state (1 = FWD, 0 = IDLE)
module xgmii_crossbar_n #(
  parameter int NUM_PORTS = 4,
  parameter int CNT_W     = 16,
  localparam int IDX_W    = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [8*NUM_PORTS-1:0]       eth_in_xgmii_ctrl,
  input  logic [64*NUM_PORTS-1:0]      eth_in_xgmii_data,
  input  logic [IDX_W*NUM_PORTS-1:0]   route_map,
  output logic [8*NUM_PORTS-1:0]       eth_out_xgmii_ctrl,
  output logic [64*NUM_PORTS-1:0]      eth_out_xgmii_data,
  output logic [CNT_W*NUM_PORTS-1:0]   drop_cnt,
  output logic [CNT_W*NUM_PORTS-1:0]   err_cnt,
  output logic [NUM_PORTS-1:0]         fwd_state
);

  localparam logic [7:0]  CTRL_ALL  = 8'hFF;
  localparam logic [63:0] IDLE_DATA = 64'h0707070707070707;
  localparam logic [63:0] ERR_DATA  = 64'hFEFEFEFEFEFEFEFE;

  typedef enum logic {IDLE = 1'b0, FWD = 1'b1} state_t;

  // Unpacked views of the flat ingress buses
  logic [7:0]       in_ctrl [NUM_PORTS];
  logic [63:0]      in_data [NUM_PORTS];
  logic [IDX_W-1:0] dst     [NUM_PORTS];
  logic [NUM_PORTS-1:0] sof, eof;

  // Per-egress registered state and its next value
  state_t           state_q [NUM_PORTS], state_d [NUM_PORTS];
  logic [IDX_W-1:0] src_q   [NUM_PORTS], src_d   [NUM_PORTS];
  logic [IDX_W-1:0] grant_q [NUM_PORTS], grant_d [NUM_PORTS];
  logic [7:0]       octrl_q [NUM_PORTS], octrl_d [NUM_PORTS];
  logic [63:0]      odata_q [NUM_PORTS], odata_d [NUM_PORTS];
  logic [CNT_W-1:0] dcnt_q  [NUM_PORTS], dcnt_d  [NUM_PORTS];
  logic [CNT_W-1:0] ecnt_q  [NUM_PORTS], ecnt_d  [NUM_PORTS];

  // Per-ingress discard flag: set when an SOF on that port was not granted
  logic [NUM_PORTS-1:0] drop_q, drop_d;

  logic [NUM_PORTS-1:0] busy, fresh, granted, lost, err_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [3:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(b);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign in_ctrl[g] = eth_in_xgmii_ctrl[8*g +: 8];
    assign in_data[g] = eth_in_xgmii_data[64*g +: 64];
    assign dst[g]     = route_map[IDX_W*g +: IDX_W];
    assign eth_out_xgmii_ctrl[8*g +: 8]  = octrl_q[g];
    assign eth_out_xgmii_data[64*g +: 64] = odata_q[g];
    assign drop_cnt[CNT_W*g +: CNT_W]    = dcnt_q[g];
    assign err_cnt[CNT_W*g +: CNT_W]     = ecnt_q[g];
    assign fwd_state[g] = (state_q[g] == FWD);
  end

  // Frame delimiters: SOF only in lane 0, EOF in any lane
  always_comb begin
    sof = '0;
    eof = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sof[i] = in_ctrl[i][0] && (in_data[i][7:0] == 8'hFB);
      for (int k = 0; k < 8; k++) begin
        if (in_ctrl[i][k] && (in_data[i][8*k +: 8] == 8'hFD)) eof[i] = 1'b1;
      end
    end
  end

  always_comb begin
    logic [IDX_W-1:0] s;
    logic             found;
    logic [3:0]       inc;
    int               cand;
    s     = '0;
    found = 1'b0;
    inc   = '0;
    cand  = 0;

    // A port that is some egress's current source can never be granted again;
    // an SOF from it aborts its frame instead.
    busy = '0;
    for (int e = 0; e < NUM_PORTS; e++) begin
      if (state_q[e] == FWD) busy[src_q[e]] = 1'b1;
    end

    fresh   = sof & ~drop_q;
    granted = '0;
    err_inc = '0;

    for (int e = 0; e < NUM_PORTS; e++) begin
      state_d[e] = state_q[e];
      src_d[e]   = src_q[e];
      grant_d[e] = grant_q[e];
      octrl_d[e] = CTRL_ALL;
      odata_d[e] = IDLE_DATA;
      if (state_q[e] == IDLE) begin
        // Round-robin: the search starts one past the last grant and wraps
        found = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
          cand = (int'(grant_q[e]) + k) % NUM_PORTS;
          if (!found && fresh[cand] && !busy[cand] && (dst[cand] == IDX_W'(e))) begin
            found         = 1'b1;
            granted[cand] = 1'b1;
            grant_d[e]    = IDX_W'(cand);
            octrl_d[e]    = in_ctrl[cand];
            odata_d[e]    = in_data[cand];
            // A single-word frame (SOF and EOF together) leaves the egress idle
            if (!eof[cand]) begin
              state_d[e] = FWD;
              src_d[e]   = IDX_W'(cand);
            end
          end
        end
      end else begin
        s = src_q[e];
        if (sof[s]) begin
          odata_d[e] = ERR_DATA;
          err_inc[e] = 1'b1;
          state_d[e] = IDLE;
        end else begin
          octrl_d[e] = in_ctrl[s];
          odata_d[e] = in_data[s];
          if (eof[s]) state_d[e] = IDLE;
        end
      end
    end

    // Every ungranted SOF (contention, busy egress, or abort) is counted at its
    // target egress, and the port discards through the frame's EOF.
    lost   = fresh & ~granted;
    drop_d = (drop_q | lost) & ~eof;

    for (int e = 0; e < NUM_PORTS; e++) begin
      inc = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (lost[i] && (dst[i] == IDX_W'(e))) inc = inc + 4'd1;
      end
      dcnt_d[e] = sat_add(dcnt_q[e], inc);
      ecnt_d[e] = sat_add(ecnt_q[e], {3'b000, err_inc[e]});
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < NUM_PORTS; e++) begin
        state_q[e] <= IDLE;
        src_q[e]   <= '0;
        grant_q[e] <= IDX_W'(NUM_PORTS - 1);
        octrl_q[e] <= CTRL_ALL;
        odata_q[e] <= IDLE_DATA;
        dcnt_q[e]  <= '0;
        ecnt_q[e]  <= '0;
      end
      drop_q <= '0;
    end else begin
      for (int e = 0; e < NUM_PORTS; e++) begin
        state_q[e] <= state_d[e];
        src_q[e]   <= src_d[e];
        grant_q[e] <= grant_d[e];
        octrl_q[e] <= octrl_d[e];
        odata_q[e] <= odata_d[e];
        dcnt_q[e]  <= dcnt_d[e];
        ecnt_q[e]  <= ecnt_d[e];
      end
      drop_q <= drop_d;
    end
  end

endmodule

// File: tb/tb_xgmii_crossbar_n.sv
// tb_xgmii_crossbar_n
//   Bench for xgmii_crossbar_n with 4 ports and 4-bit counters (so saturation
//   is reachable). A frame-level reference model predicts every egress word and
//   counter one cycle ahead; hand sequences add fixed expectations.
module tb_xgmii_crossbar_n;
  localparam int NP   = 4;
  localparam int CW   = 4;
  localparam int IW   = 2;
  localparam int CMAX = 15;
  localparam int OW   = NP * 72;
  localparam int CT   = 2 * NP * CW;
  localparam int EW   = OW + CT;
  localparam logic [63:0] IDLE_D = 64'h0707070707070707;
  localparam logic [63:0] ERR_D  = 64'hFEFEFEFEFEFEFEFE;

  // Word kinds for set_word
  localparam int K_IDLE = 0, K_SOF = 1, K_DATA = 2, K_EOF = 3, K_ONE = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [8*NP-1:0]  in_c;
  logic [64*NP-1:0] in_d;
  logic [IW*NP-1:0] rm;
  logic [8*NP-1:0]  out_c;
  logic [64*NP-1:0] out_d;
  logic [CW*NP-1:0] dcnt, ecnt;
  logic [NP-1:0]    fwd_state;

  xgmii_crossbar_n #(.NUM_PORTS(NP), .CNT_W(CW)) dut (
    .clk                (clk),
    .reset              (reset),
    .eth_in_xgmii_ctrl  (in_c),
    .eth_in_xgmii_data  (in_d),
    .route_map          (rm),
    .eth_out_xgmii_ctrl (out_c),
    .eth_out_xgmii_data (out_d),
    .drop_cnt           (dcnt),
    .err_cnt            (ecnt),
    .fwd_state          (fwd_state)
  );

  // ---------------- stimulus state ----------------
  logic [7:0]  sc [NP];
  logic [63:0] sd [NP];
  int          rt [NP];

  // ---------------- reference model state ----------------
  int owner [NP];   // source ingress per egress, -1 when idle
  bit disc  [NP];   // ingress currently discarding a lost frame
  int lg    [NP];   // last granted ingress per egress
  int mdrop [NP];
  int merr  [NP];

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_egress(input string name, input int e, input logic [7:0] c, input logic [63:0] d);
    chk(name, EW'({out_c[8*e +: 8], out_d[64*e +: 64]}), EW'({c, d}));
  endtask

  function automatic logic [7:0] wc(input int kind);
    case (kind)
      K_SOF:   return 8'h01;
      K_DATA:  return 8'h00;
      K_EOF:   return 8'hF0;
      K_ONE:   return 8'h81;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] wd(input int kind, input logic [7:0] t);
    case (kind)
      K_SOF:   return {{7{t}}, 8'hFB};
      K_DATA:  return {8{t}};
      K_EOF:   return {24'h070707, 8'hFD, {4{t}}};
      K_ONE:   return {8'hFD, {6{t}}, 8'hFB};
      default: return IDLE_D;
    endcase
  endfunction

  task automatic set_word(input int i, input int kind, input logic [7:0] t);
    sc[i] = wc(kind);
    sd[i] = wd(kind, t);
  endtask

  task automatic all_idle();
    for (int i = 0; i < NP; i++) set_word(i, K_IDLE, 8'h00);
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int e = 0; e < NP; e++) begin
      owner[e] = -1;
      disc[e]  = 1'b0;
      lg[e]    = NP - 1;
      mdrop[e] = 0;
      merr[e]  = 0;
    end
    exp_q.delete();
  endtask

  // Predicts what the egresses show after the coming edge, given sc/sd/rt.
  task automatic model_step();
    bit is_sof [NP];
    bit is_eof [NP];
    bit busy   [NP];
    bit won    [NP];
    bit ndisc  [NP];
    int nown   [NP];
    int req[$];
    int s, best, bestd, d;
    logic [8*NP-1:0]  fc;
    logic [64*NP-1:0] fd;
    logic [CW*NP-1:0] fdr, fer;
    for (int i = 0; i < NP; i++) begin
      is_sof[i] = sc[i][0] && (sd[i][7:0] == 8'hFB);
      is_eof[i] = 1'b0;
      for (int k = 0; k < 8; k++)
        if (sc[i][k] && (sd[i][8*k +: 8] == 8'hFD)) is_eof[i] = 1'b1;
      busy[i] = 1'b0;
      won[i]  = 1'b0;
    end
    for (int e = 0; e < NP; e++) if (owner[e] >= 0) busy[owner[e]] = 1'b1;
    for (int e = 0; e < NP; e++) begin
      fc[8*e +: 8]   = 8'hFF;
      fd[64*e +: 64] = IDLE_D;
      nown[e] = owner[e];
      if (owner[e] >= 0) begin
        s = owner[e];
        if (is_sof[s]) begin
          fd[64*e +: 64] = ERR_D;
          merr[e] = sat(merr[e] + 1);
          nown[e] = -1;
        end else begin
          fc[8*e +: 8]   = sc[s];
          fd[64*e +: 64] = sd[s];
          if (is_eof[s]) nown[e] = -1;
        end
      end else begin
        req.delete();
        for (int c = 0; c < NP; c++)
          if (is_sof[c] && !disc[c] && !busy[c] && rt[c] == e) req.push_back(c);
        best = -1;
        bestd = NP;
        // Nearest requester above the last grant, cyclically
        foreach (req[j]) begin
          d = (req[j] - lg[e] - 1 + NP) % NP;
          if (d < bestd) begin
            bestd = d;
            best  = req[j];
          end
        end
        if (best >= 0) begin
          won[best] = 1'b1;
          lg[e] = best;
          fc[8*e +: 8]   = sc[best];
          fd[64*e +: 64] = sd[best];
          nown[e] = is_eof[best] ? -1 : best;
        end
      end
    end
    for (int i = 0; i < NP; i++) begin
      ndisc[i] = disc[i] && !is_eof[i];
      if (is_sof[i] && !disc[i] && !won[i]) begin
        mdrop[rt[i]] = sat(mdrop[rt[i]] + 1);
        if (!is_eof[i]) ndisc[i] = 1'b1;
      end
    end
    for (int i = 0; i < NP; i++) begin
      disc[i]  = ndisc[i];
      owner[i] = nown[i];
      fdr[CW*i +: CW] = CW'(mdrop[i]);
      fer[CW*i +: CW] = CW'(merr[i]);
    end
    exp_q.push_back({fc, fd, fdr, fer});
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    logic [EW-1:0] exp;
    for (int i = 0; i < NP; i++) begin
      in_c[8*i +: 8]   = sc[i];
      in_d[64*i +: 64] = sd[i];
      rm[IW*i +: IW]   = IW'(rt[i]);
    end
    model_step();
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    chk("model_words", EW'({out_c, out_d}), EW'(exp[EW-1 -: OW]));
    chk("model_counters", EW'({dcnt, ecnt}), EW'(exp[CT-1:0]));
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    all_idle();
    for (int i = 0; i < NP; i++) rt[i] = 0;
    for (int i = 0; i < NP; i++) begin
      in_c[8*i +: 8]   = sc[i];
      in_d[64*i +: 64] = sd[i];
      rm[IW*i +: IW]   = '0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  // ---------------- table-driven frame ----------------
  typedef struct {
    logic [7:0]  ic;
    logic [63:0] id;
    logic [7:0]  xc;
    logic [63:0] xd;
  } vec_t;
  vec_t tv [9];

  int len_left [NP];
  int r;

  initial begin
    // 8-word frame: expected egress word equals the ingress word one cycle later
    tv[0] = '{8'h01, 64'hD5555555555555FB, 8'h01, 64'hD5555555555555FB};
    for (int j = 1; j <= 6; j++)
      tv[j] = '{8'h00, 64'h0123456789ABCDEF + 64'(j), 8'h00, 64'h0123456789ABCDEF + 64'(j)};
    tv[7] = '{8'hF0, 64'h070707FDA1B2C3D4, 8'hF0, 64'h070707FDA1B2C3D4};
    tv[8] = '{8'hFF, IDLE_D, 8'hFF, IDLE_D};

    reset_dut();
    chk("reset_ctrl", EW'(out_c), EW'({NP{8'hFF}}));
    chk("reset_data", EW'(out_d), EW'({NP{IDLE_D}}));
    chk("reset_counters", EW'({dcnt, ecnt}), EW'(0));

    // Single frame port0 -> egress2
    rt[0] = 2;
    for (int j = 0; j < 9; j++) begin
      sc[0] = tv[j].ic;
      sd[0] = tv[j].id;
      tick();
      chk_egress("frame_p0_e2", 2, tv[j].xc, tv[j].xd);
      if (j == 0) chk("fsm_fwd_e2", EW'(fwd_state), EW'(4'b0100));
    end
    chk("frame_drop_e2", EW'(dcnt[8 +: CW]), EW'(0));

    // Contention on egress0: port1 wins first, port3 next time
    reset_dut();
    rt[1] = 0; rt[3] = 0;
    for (int rep = 0; rep < 2; rep++) begin
      set_word(1, K_SOF, 8'h11); set_word(3, K_SOF, 8'h33);
      tick();
      chk_egress("contend_sof", 0, 8'h01, wd(K_SOF, (rep == 0) ? 8'h11 : 8'h33));
      set_word(1, K_DATA, 8'h12); set_word(3, K_DATA, 8'h34);
      tick();
      chk_egress("contend_data", 0, 8'h00, wd(K_DATA, (rep == 0) ? 8'h12 : 8'h34));
      set_word(1, K_EOF, 8'h13); set_word(3, K_EOF, 8'h35);
      tick();
      chk_egress("contend_eof", 0, 8'hF0, wd(K_EOF, (rep == 0) ? 8'h13 : 8'h35));
      all_idle();
      tick();
      chk_egress("contend_idle", 0, 8'hFF, IDLE_D);
      chk("contend_drop_e0", EW'(dcnt[0 +: CW]), EW'(rep + 1));
    end

    // SOF to an egress already forwarding another port
    reset_dut();
    rt[0] = 1; rt[2] = 1;
    set_word(0, K_SOF, 8'hA0); tick();
    set_word(0, K_DATA, 8'hA1); set_word(2, K_SOF, 8'hC2); tick();
    chk_egress("busy_keep", 1, 8'h00, wd(K_DATA, 8'hA1));
    set_word(0, K_DATA, 8'hA2); set_word(2, K_DATA, 8'hC3); tick();
    set_word(0, K_EOF, 8'hA3); set_word(2, K_EOF, 8'hC4); tick();
    chk_egress("busy_eof", 1, 8'hF0, wd(K_EOF, 8'hA3));
    all_idle(); tick();
    chk("busy_drop_e1", EW'(dcnt[CW +: CW]), EW'(1));

    // Abort: second SOF without EOF on the forwarding port
    reset_dut();
    set_word(0, K_SOF, 8'h50); tick();
    for (int j = 0; j < 3; j++) begin set_word(0, K_DATA, 8'h51 + 8'(j)); tick(); end
    set_word(0, K_SOF, 8'h60); tick();
    chk_egress("abort_err_word", 0, 8'hFF, ERR_D);
    chk("abort_err_cnt", EW'(ecnt[0 +: CW]), EW'(1));
    set_word(0, K_DATA, 8'h61); tick();
    chk_egress("abort_discard", 0, 8'hFF, IDLE_D);
    set_word(0, K_EOF, 8'h62); tick();
    chk_egress("abort_discard_eof", 0, 8'hFF, IDLE_D);
    all_idle(); tick();

    // route_map change mid-frame
    reset_dut();
    rt[0] = 1;
    set_word(0, K_SOF, 8'h70); tick();
    rt[0] = 2;
    set_word(0, K_DATA, 8'h71); tick();
    set_word(0, K_EOF, 8'h72); tick();
    chk_egress("remap_old_eof", 1, 8'hF0, wd(K_EOF, 8'h72));
    all_idle(); tick();
    set_word(0, K_SOF, 8'h73); tick();
    chk_egress("remap_new_sof", 2, 8'h01, wd(K_SOF, 8'h73));
    set_word(0, K_EOF, 8'h74); tick();
    all_idle(); tick();

    // Counter saturation: two single-word frames collide every cycle
    reset_dut();
    for (int j = 0; j < 20; j++) begin
      set_word(1, K_ONE, 8'(j)); set_word(2, K_ONE, 8'(j + 100));
      tick();
    end
    chk("sat_drop_e0", EW'(dcnt[0 +: CW]), EW'(CMAX));
    all_idle(); tick();

    // Reset mid-frame: outputs idle without waiting for an edge
    reset_dut();
    rt[0] = 3; rt[1] = 3;
    set_word(0, K_SOF, 8'h80); set_word(1, K_SOF, 8'h90); tick();
    set_word(0, K_DATA, 8'h81); set_word(1, K_DATA, 8'h91); tick();
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_ctrl", EW'(out_c), EW'({NP{8'hFF}}));
    chk("midreset_data", EW'(out_d), EW'({NP{IDLE_D}}));
    chk("midreset_counters", EW'({dcnt, ecnt}), EW'(0));
    @(posedge clk);
    reset_dut();
    // First grant after reset goes to ingress 0
    rt[0] = 1; rt[3] = 1;
    set_word(0, K_SOF, 8'hB0); set_word(3, K_SOF, 8'hB3); tick();
    chk_egress("first_grant_p0", 1, 8'h01, wd(K_SOF, 8'hB0));
    set_word(0, K_EOF, 8'hB1); set_word(3, K_EOF, 8'hB4); tick();
    all_idle(); tick();

    // Random traffic against the model
    reset_dut();
    for (int i = 0; i < NP; i++) len_left[i] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NP; i++) begin
        if (len_left[i] == 0) begin
          r = $urandom_range(0, 9);
          if (r < 3) begin
            set_word(i, K_SOF, 8'($urandom));
            len_left[i] = $urandom_range(1, 6);
          end else if (r == 3) set_word(i, K_ONE, 8'($urandom));
          else set_word(i, K_IDLE, 8'h00);
        end else begin
          r = $urandom_range(0, 19);
          if (r == 0) begin
            set_word(i, K_SOF, 8'($urandom));
            len_left[i] = $urandom_range(1, 6);
          end else if (len_left[i] == 1) begin
            set_word(i, K_EOF, 8'($urandom));
            len_left[i] = 0;
          end else begin
            sc[i] = 8'h00;
            sd[i] = {$urandom, $urandom};
            len_left[i]--;
          end
        end
        rt[i] = $urandom_range(0, NP - 1);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xgmii_crossbar_n.md
XGMII_CROSSBAR_N -- requirements
Module: xgmii_crossbar_n

Interface
REQ-001 The block SHALL expose parameter NUM_PORTS, default 4, number of XGMII ingress and egress ports, legal range 2..8.
REQ-002 The block SHALL expose parameter CNT_W, default 16, width of each per-egress drop counter and error counter.
REQ-003 The block SHALL derive localparam IDX_W = clog2(NUM_PORTS), minimum 1.
REQ-004 clk  input  1  single clock; all state SHALL be on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 eth_in_xgmii_ctrl  input  8*NUM_PORTS  per-port XGMII control; port i uses bits [8i+7:8i].
REQ-007 eth_in_xgmii_data  input  64*NUM_PORTS  per-port XGMII data; port i uses bits [64i+63:64i].
REQ-008 route_map  input  IDX_W*NUM_PORTS  destination egress index for each ingress port i.
REQ-009 eth_out_xgmii_ctrl  output  8*NUM_PORTS  per-egress XGMII control, registered.
REQ-010 eth_out_xgmii_data  output  64*NUM_PORTS  per-egress XGMII data, registered.
REQ-011 drop_cnt  output  CNT_W*NUM_PORTS  per-egress count of frames lost to contention.
REQ-012 err_cnt  output  CNT_W*NUM_PORTS  per-egress count of aborted frames.

Function
REQ-013 SOF on ingress i SHALL be ctrl[0]=1 with data[7:0]=8'hFB; EOF SHALL be any lane k with ctrl[k]=1 and data byte k = 8'hFD.
REQ-014 Each egress SHALL run its own FSM with two states: IDLE and FWD(src).
REQ-015 IDLE: the egress SHALL emit the idle word, ctrl=8'hFF and data=64'h0707070707070707.
REQ-016 IDLE: candidates SHALL be ingress ports showing SOF this cycle with route_map[i] equal to this egress; route_map SHALL be sampled only at SOF.
REQ-017 Arbitration SHALL be round-robin, searching upward from last_grant+1 with wrap at NUM_PORTS-1 to 0; the winner SHALL set last_grant and move the FSM to FWD(winner).
REQ-018 The granted SOF word SHALL appear on the egress one cycle later; forward latency SHALL be exactly 1 cycle for every word.
REQ-019 FWD(src): each cycle the egress SHALL register the src ingress word unchanged.
REQ-020 FWD(src): EOF on src SHALL forward that word and return the FSM to IDLE on the next edge.
REQ-021 A word carrying both SOF and EOF SHALL be a complete frame; the FSM SHALL stay IDLE after it.
REQ-022 Each losing SOF candidate SHALL set that ingress port's drop flag and increment the target egress drop_cnt by 1.
REQ-023 An SOF mapped to an egress already in FWD SHALL also be dropped and counted.
REQ-024 A dropped ingress SHALL discard words through its EOF inclusive, then clear its drop flag.
REQ-025 A new SOF on src while in FWD(src) SHALL cause the egress to emit the error word (ctrl=8'hFF, data=64'hFEFEFEFEFEFEFEFE) instead of that word, increment err_cnt, and return to IDLE.
REQ-026 An SOF on src that causes an abort SHALL NOT start a new frame; the remainder of that frame SHALL be treated as dropped.
REQ-027 Non-SOF words on ingress ports that are neither granted nor dropped SHALL be ignored.
REQ-028 Counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-029 When one ingress port causes both a drop increment and an err increment in the same cycle, both SHALL apply.
REQ-030 route_map changes during a frame SHALL NOT affect that frame.

Reset
REQ-031 On reset low, all outputs SHALL assert immediately (asynchronously) to the idle word, with drop_cnt=0 and err_cnt=0.
REQ-032 On reset low, all FSMs SHALL enter IDLE, last_grant SHALL be NUM_PORTS-1, and all drop flags SHALL clear.
REQ-033 Reset asserted mid-frame SHALL abandon the frame without emitting the error word.
REQ-034 After reset release, the first grant SHALL be ingress 0 if it requests.

Verification
REQ-035 Scenario: port0 to egress2 sends an 8-word frame -> egress2 carries the same 8 words delayed 1 cycle, then the idle word; drop_cnt[2]=0.
REQ-036 Scenario: ports 1 and 3 SOF to egress0 in the same cycle after reset -> port1 forwarded, port3 frame fully absent, drop_cnt[0]=1; repeat -> port3 wins.
REQ-037 Scenario: port2 SOF to egress1 while port0 is mid-frame on egress1 -> port0 frame intact, drop_cnt[1]=1.
REQ-038 Scenario: port0 sends SOF, 3 data words, then SOF with no EOF -> egress emits the FE word in place of the 2nd SOF, err_cnt=1, the following words are not forwarded.
REQ-039 Scenario: route_map[0] changes 1->2 mid-frame -> the current frame completes on egress1; the next frame goes to egress2.
REQ-040 Scenario: reset pulsed low mid-frame -> outputs go idle before the next clk edge, counters read 0.
